// File: rtl/prover_compute_w0_seq.sv
// w0 sequencer: w0[i] = w1[i] + tau*(w2[i]-w1[i]) mod p (p = 2^61-1), one shared element unit.
// Optional W0_SKIP_ZERO_EN: elements whose (w2-w1) is zero bypass the element unit in one cycle.

module field_multiplier #(
  parameter int F_NBITS = 61
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               en_i,
  input  logic [F_NBITS-1:0] a_i,
  input  logic [F_NBITS-1:0] b_i,
  output logic               ready_pulse_o,
  output logic [F_NBITS-1:0] c_o
);
  localparam logic [F_NBITS-1:0] P = '1;

  // Mersenne fold: for reduced operands the second fold cannot carry out.
  function automatic logic [F_NBITS-1:0] mod_fold(input logic [2*F_NBITS-1:0] x);
    logic [F_NBITS:0]   s1;
    logic [F_NBITS-1:0] s2;
    s1 = {1'b0, x[F_NBITS-1:0]} + {1'b0, x[2*F_NBITS-1:F_NBITS]};
    s2 = s1[F_NBITS-1:0] + {{(F_NBITS-1){1'b0}}, s1[F_NBITS]};
    return (s2 == P) ? '0 : s2;
  endfunction

  logic [2*F_NBITS-1:0] prod_p0;
  logic [F_NBITS-1:0]   c_p1;
  logic                 vld_p0, vld_p1;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= en_i;
      vld_p1 <= vld_p0;
    end
  end

  // p0: raw product; p1: reduced result
  always_ff @(posedge clk) begin
    prod_p0 <= {{F_NBITS{1'b0}}, a_i} * {{F_NBITS{1'b0}}, b_i};
    c_p1    <= mod_fold(prod_p0);
  end

  assign ready_pulse_o = vld_p1;
  assign c_o           = c_p1;
endmodule

module field_adder #(
  parameter int F_NBITS = 61
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               en_i,
  input  logic [F_NBITS-1:0] a_i,
  input  logic [F_NBITS-1:0] b_i,
  output logic               ready_pulse_o,
  output logic [F_NBITS-1:0] c_o
);
  localparam logic [F_NBITS-1:0] P = '1;

  function automatic logic [F_NBITS-1:0] mod_add(input logic [F_NBITS-1:0] a,
                                                 input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[F_NBITS-1:0];
  endfunction

  logic [F_NBITS-1:0] c_p0;
  logic               vld_p0;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) vld_p0 <= 1'b0;
    else       vld_p0 <= en_i;
  end

  // p0: reduced sum
  always_ff @(posedge clk) begin
    c_p0 <= mod_add(a_i, b_i);
  end

  assign ready_pulse_o = vld_p0;
  assign c_o           = c_p0;
endmodule

module prover_compute_w0_elem #(
  parameter int F_NBITS = 61
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               en_i,
  input  logic [F_NBITS-1:0] w1_i,
  input  logic [F_NBITS-1:0] w2_m_w1_i,
  input  logic [F_NBITS-1:0] tau_i,
  output logic               ready_pulse_o,
  output logic [F_NBITS-1:0] w0_o
);
  logic [F_NBITS-1:0] w1_p0, dm_p0, tau_p0, prod;
  logic               vld_p0, mul_vld;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) vld_p0 <= 1'b0;
    else       vld_p0 <= en_i;
  end

  // p0: operand capture; w1_p0 stays put until the adder consumes it
  always_ff @(posedge clk) begin
    if (en_i) begin
      w1_p0  <= w1_i;
      dm_p0  <= w2_m_w1_i;
      tau_p0 <= tau_i;
    end
  end

  field_multiplier #(.F_NBITS(F_NBITS)) u_mul (
    .clk           (clk),
    .rstb          (rstb),
    .en_i          (vld_p0),
    .a_i           (tau_p0),
    .b_i           (dm_p0),
    .ready_pulse_o (mul_vld),
    .c_o           (prod)
  );

  field_adder #(.F_NBITS(F_NBITS)) u_add (
    .clk           (clk),
    .rstb          (rstb),
    .en_i          (mul_vld),
    .a_i           (prod),
    .b_i           (w1_p0),
    .ready_pulse_o (ready_pulse_o),
    .c_o           (w0_o)
  );
endmodule

module prover_compute_w0_seq #(
  parameter  int NELMS   = 8,
  localparam int F_NBITS = 61,
  localparam int IW      = (NELMS > 1) ? $clog2(NELMS) : 1
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     en,
  input  logic [F_NBITS-1:0]       tau,
  input  logic [NELMS*F_NBITS-1:0] w1,
  input  logic [NELMS*F_NBITS-1:0] w2_m_w1,
  output logic                     ready,
  output logic                     ready_pulse,
  output logic [NELMS*F_NBITS-1:0] w0
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                   state_q;
  logic [IW-1:0]            idx_q;
  logic [F_NBITS-1:0]       tau_q;
  logic [NELMS*F_NBITS-1:0] w0_q;
  logic                     ready_q, ready_pulse_q;

  logic [F_NBITS-1:0] w1_sel, dm_sel, elem_res, wr_val;
  logic               elem_en, elem_done, skip, last, step;

  assign w1_sel = w1[int'(idx_q)*F_NBITS +: F_NBITS];
  assign dm_sel = w2_m_w1[int'(idx_q)*F_NBITS +: F_NBITS];

`ifdef W0_SKIP_ZERO_EN
  assign skip = (state_q == ISSUE) && (dm_sel == '0);
`else
  assign skip = 1'b0;
`endif

  assign elem_en = (state_q == ISSUE) && !skip;
  assign last    = (int'(idx_q) == NELMS - 1);
  // A slot completes either through the element unit or via the zero-difference bypass.
  assign step    = skip || ((state_q == WAIT) && elem_done);
  assign wr_val  = skip ? w1_sel : elem_res;

  prover_compute_w0_elem #(.F_NBITS(F_NBITS)) u_elem (
    .clk           (clk),
    .rstb          (rstb),
    .en_i          (elem_en),
    .w1_i          (w1_sel),
    .w2_m_w1_i     (dm_sel),
    .tau_i         (tau_q),
    .ready_pulse_o (elem_done),
    .w0_o          (elem_res)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      tau_q         <= '0;
      w0_q          <= '0;
      ready_q       <= 1'b1;
      ready_pulse_q <= 1'b0;
    end else begin
      ready_pulse_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (en) begin
            tau_q   <= tau;
            idx_q   <= '0;
            state_q <= ISSUE;
            ready_q <= 1'b0;
          end
        end
        ISSUE: begin
          if (!skip) state_q <= WAIT;
        end
        WAIT: ;
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
      if (step) begin
        w0_q[int'(idx_q)*F_NBITS +: F_NBITS] <= wr_val;
        if (last) begin
          state_q       <= DONE;
          ready_pulse_q <= 1'b1;
        end else begin
          idx_q   <= idx_q + 1'b1;
          state_q <= ISSUE;
        end
      end
    end
  end

  assign ready       = ready_q;
  assign ready_pulse = ready_pulse_q;
  assign w0          = w0_q;
endmodule
